shift_delay_ctrl: RTL and testbench
===================================

# shift_delay_ctrl

Sequencing controller plus storage for the signed sample delay line. It accepts WIDTH-bit signed samples over a valid/ready handshake and shifts them through a DEPTH-entry line. It emits each sample exactly D accepted samples later, where D is loaded at run time. It also handles priming (fill), output backpressure and an ordered drain on flush, which replaces the free-running counter/fixed-tap capture scheme with a handshaked, configurable delay.

## Interface
Parameters:
- WIDTH, 7, sample width (signed two's complement)
- DEPTH, 33, number of delay-line entries (maximum delay)
- CW, $clog2(DEPTH+1), width of delay/fill counters

Ports:
- clk  input  1  rising-edge clock; one clock for the whole block
- rstn  input  1  reset; synchronous and active-low
- cfg_load  input  1  load cfg_delay; honoured only in IDLE
- cfg_delay  input  CW  requested delay D
- flush  input  1  drain stored samples and return to IDLE
- in_valid  input  1  input sample valid
- in_ready  output  1  input accepted when in_valid && in_ready
- in_data  input  WIDTH  signed input sample
- out_valid  output  1  output sample valid
- out_ready  input  1  output consumed when out_valid && out_ready
- out_data  output  WIDTH  signed delayed sample
- fill_cnt  output  CW  samples currently held in the line (0..D)
- busy  output  1  (state != IDLE) || out_valid

## Operation
- The storage is tap[0..DEPTH-1]. On an accept, it shifts tap[i] <= tap[i-1] and tap[0] <= in_data. It never shifts otherwise.
- Data is passed through bit-exact. There is no arithmetic on samples and no sign change.
- **IDLE** (after reset):
  - in_ready = 0.
  - cfg_load latches D = clamp(cfg_delay): 0 becomes 1, and values above DEPTH become DEPTH.
  - On cfg_load, fill_cnt <= 0 and the state goes to FILL.
  - flush is ignored.
- **FILL**:
  - in_ready = !flush.
  - Each accept shifts and does fill_cnt++.
  - When an accept makes fill_cnt == D, the state goes to RUN. No output is produced in FILL.
- **RUN**:
  - in_ready = !flush && (!out_valid || out_ready).
  - On an accept: out_data <= tap[D-1] (the value before the shift), out_valid <= 1, then shift. fill_cnt stays at D.
  - On an output handshake with no accept: out_valid <= 0.
- **FLUSH**: entered from FILL or RUN when flush = 1 (flush has priority over a same-cycle in_valid, which is not accepted).
  - in_ready = 0.
  - Each cycle with (!out_valid || out_ready) and fill_cnt > 0: out_data <= tap[fill_cnt-1], out_valid <= 1, fill_cnt--. Samples drain oldest first.
  - When fill_cnt == 0 and (!out_valid || out_ready): out_valid <= 0 and the state goes to IDLE.
- cfg_load outside IDLE is ignored. flush while already in FLUSH has no extra effect.
- **Reset** (rstn = 0 at a clock edge, in any state, including mid-drain):
  - state = IDLE, D = 1, fill_cnt = 0, out_valid = 0, out_data = 0, all tap entries cleared.
  - Because in_ready and busy are derived from these values, in_ready = 0 and busy = 0.

## Timing
- out_data, out_valid and fill_cnt are registered. in_ready and busy are combinational from registered state, out_valid and out_ready (in_ready also from flush). There is no combinational path from in_valid or in_data.
- Latency: sample n appears on out_data in the cycle after sample n+D is accepted.
- Throughput: one sample per cycle with out_ready held high.
- Under backpressure, out_valid stays high and out_data is held stable until the handshake. No samples are lost or duplicated.
- FLUSH emits at most one sample per cycle. The drain takes at least fill_cnt cycles plus the cycles stalled on out_ready. IDLE is reached the cycle after the last handshake.
- Boundaries:
  - With D = 1 the line behaves as a one-deep stage: FILL lasts one accept.
  - With D = DEPTH, the value tap[DEPTH-1] is output before the shift, so it is never lost.

## Test plan
- **Reset mid-RUN:** hold rstn = 0 for 1 cycle during streaming -> next cycle: out_valid = 0, out_data = 0, in_ready = 0, fill_cnt = 0, busy = 0. After reset, cfg_delay = 2 and stream 5, 6, 7 -> output is 5, with no stale data.
- **Basic delay:** cfg_delay = 3, stream 1..10 back-to-back, out_ready = 1 -> the first out_valid comes the cycle after sample 4 is accepted. Outputs are 1..7 in order, one per cycle, and fill_cnt = 3 throughout RUN.
- **Backpressure:** cfg_delay = 2, stream 1..6, drop out_ready for 5 cycles after the first output -> in_ready = 0 while stalled and out_data is held at 1. After release, outputs 1, 2, 3, 4 arrive with no loss or duplication.
- **Flush from FILL:** cfg_delay = 8, accept 1..5, then assert flush together with in_valid (data 99) -> 99 is not accepted. Outputs are 1, 2, 3, 4, 5, then IDLE with busy = 0. Repeat with out_ready toggling every other cycle and get the same order.
- **Flush from RUN:** cfg_delay = 4, stream 1..9, flush -> after the RUN outputs 1..5, the drain emits 6, 7, 8, 9, then IDLE.
- **Clamping and signed extremes:**
  - cfg_delay = 0 -> D = 1.
  - cfg_delay = 40 with DEPTH = 33 -> D = 33: 33 accepts are needed before the first output.
  - Samples -64 and 63 (WIDTH = 7) pass through bit-exact.

Source files
------------

// File: rtl/shift_delay_ctrl.sv
// shift_delay_ctrl: handshaked signed delay line with run-time delay,
// priming, output backpressure and an ordered oldest-first drain on flush.
module shift_delay_ctrl #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 33,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_load,
    input  logic [CW-1:0]           cfg_delay,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [CW-1:0]           fill_cnt,
    output logic                    busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DMAX = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           dly_q, dly_d;
    logic [CW-1:0]           fill_q, fill_d;
    logic                    ov_q, ov_d;
    logic signed [WIDTH-1:0] od_q, od_d;
    logic signed [WIDTH-1:0] tap_q [DEPTH];
    logic signed [WIDTH-1:0] tap_d [DEPTH];

    logic          accept;
    logic          out_hs;
    logic          out_free;
    logic          shift;
    logic [CW-1:0] dly_clamp;
    logic [AW-1:0] run_idx;
    logic [AW-1:0] drain_idx;

    // Input acceptance: never while idle or draining, and flush wins.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_FILL:  in_ready = !flush;
            S_RUN:   in_ready = !flush && (!ov_q || out_ready);
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign out_hs    = ov_q && out_ready;
    assign out_free  = !ov_q || out_ready;
    assign run_idx   = AW'(dly_q - ONE);
    assign drain_idx = AW'(fill_q - ONE);

    // Requested delay limited to 1..DEPTH.
    always_comb begin
        dly_clamp = cfg_delay;
        if (cfg_delay == '0) begin
            dly_clamp = ONE;
        end else if (cfg_delay > DMAX) begin
            dly_clamp = DMAX;
        end
    end

    // Sequencing: state, delay, fill count and the output register.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        fill_d  = fill_q;
        ov_d    = ov_q;
        od_d    = od_q;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    dly_d   = dly_clamp;
                    fill_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (accept) begin
                    shift  = 1'b1;
                    fill_d = fill_q + ONE;
                    if ((fill_q + ONE) == dly_q) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    od_d  = tap_q[run_idx];
                    ov_d  = 1'b1;
                    shift = 1'b1;
                end else if (out_hs) begin
                    ov_d = 1'b0;
                end
                if (flush) begin
                    state_d = S_FLUSH;
                end
            end
            default: begin
                if (out_free) begin
                    if (fill_q != '0) begin
                        od_d   = tap_q[drain_idx];
                        ov_d   = 1'b1;
                        fill_d = fill_q - ONE;
                    end else begin
                        ov_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    // Delay line moves only on an accepted sample.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tap_d[i] = tap_q[i];
        end
        if (shift) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                tap_d[i] = tap_q[i-1];
            end
            tap_d[0] = in_data;
        end
    end

    // State and storage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            dly_q   <= ONE;
            fill_q  <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            fill_q  <= fill_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            for (int i = 0; i < DEPTH; i++) begin
                tap_q[i] <= tap_d[i];
            end
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign fill_cnt  = fill_q;
    assign busy      = (state_q != S_IDLE) || ov_q;

endmodule

// File: tb/tb_shift_delay_ctrl.sv
// tb_shift_delay_ctrl: randomized and directed stimulus against a
// queue-based delay model, with a decoupled output scoreboard.
module tb_shift_delay_ctrl;

    localparam int WIDTH = 7;
    localparam int DEPTH = 33;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    cfg_load = 1'b0;
    logic [CW-1:0]           cfg_delay = '0;
    logic                    flush = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH-1:0] out_data;
    logic [CW-1:0]           fill_cnt;
    logic                    busy;

    int checks = 0;
    int errors = 0;
    int rmode  = 0;

    always #5 clk = ~clk;

    shift_delay_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_load (cfg_load),
        .cfg_delay(cfg_delay),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .fill_cnt (fill_cnt),
        .busy     (busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: a queue of held samples and an abstract mode.
    typedef enum {M_IDLE, M_FILL, M_RUN, M_FLUSH} mode_t;
    mode_t mode = M_IDLE;
    int    dly  = 1;
    bit    pend_ov = 1'b0;
    logic signed [WIDTH-1:0] hist [$];
    logic signed [WIDTH-1:0] expq [$];

    function automatic int clampd(input int x);
        if (x == 0) return 1;
        if (x > DEPTH) return DEPTH;
        return x;
    endfunction

    always @(negedge clk) begin : model
        bit exp_rdy;
        bit acc;
        if (!rstn) begin
            mode = M_IDLE;
            dly  = 1;
            pend_ov = 1'b0;
            hist.delete();
            expq.delete();
        end else begin
            if (pend_ov) chk("latency_ov", out_valid, 1);
            pend_ov = 1'b0;
            case (mode)
                M_FILL:  exp_rdy = !flush;
                M_RUN:   exp_rdy = !flush && (!out_valid || out_ready);
                default: exp_rdy = 1'b0;
            endcase
            chk("in_ready", in_ready, exp_rdy);
            if (mode == M_FILL || mode == M_RUN)
                chk("fill_cnt", fill_cnt, hist.size());
            if (mode == M_FILL)
                chk("fill_no_out", out_valid, 0);
            if (mode != M_FLUSH)
                chk("busy", busy, (mode != M_IDLE) || out_valid);
            acc = in_valid && exp_rdy;
            case (mode)
                M_IDLE: begin
                    if (cfg_load) begin
                        dly  = clampd(int'(cfg_delay));
                        mode = M_FILL;
                    end
                end
                M_FILL, M_RUN: begin
                    if (flush) begin
                        while (hist.size() > 0)
                            expq.push_back(hist.pop_front());
                        mode = M_FLUSH;
                    end else if (acc) begin
                        hist.push_back(in_data);
                        if (hist.size() > dly) begin
                            expq.push_back(hist.pop_front());
                            pend_ov = 1'b1;
                        end
                        if (hist.size() == dly) mode = M_RUN;
                    end
                end
                default: begin
                    if (!busy) begin
                        chk("drain_done", expq.size(), 0);
                        mode = M_IDLE;
                    end
                end
            endcase
        end
    end

    // Output monitor: pops the scoreboard on every output handshake.
    logic signed [WIDTH-1:0] prev_d = '0;
    bit prev_stall = 1'b0;

    always @(negedge clk) begin : monitor
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_extra: got %0d expected none",
                             out_data);
                end else begin
                    chk("out_data", out_data, expq.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
        end
    end

    // Output-ready pattern generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cfg_load = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic cfg(input int d);
        cfg_load = 1'b1;
        cfg_delay = CW'(d);
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic send(input int v);
        bit ok;
        in_valid = 1'b1;
        in_data = WIDTH'(v);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck 0 expected 1");
    endtask

    task automatic do_flush(input bit with_in, input int v);
        flush = 1'b1;
        in_valid = with_in;
        in_data = WIDTH'(v);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (!busy) begin
                tick();
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: busy stuck 1 expected 0", nm);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation stalled");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fill", fill_cnt, 0);
        chk("rst_busy", busy, 0);
        tick();

        // basic delay of 3
        rmode = 0;
        cfg(3);
        for (int i = 1; i <= 10; i++) send(i);
        do_flush(1'b0, 0);
        wait_idle("basic");

        // backpressure
        cfg(2);
        for (int i = 1; i <= 3; i++) send(i);
        rmode = 3;
        in_valid = 1'b1;
        in_data = WIDTH'(4);
        repeat (5) tick();
        rmode = 0;
        for (int i = 4; i <= 6; i++) send(i);
        do_flush(1'b0, 0);
        wait_idle("bp");

        // flush from FILL, plain then with toggling ready
        for (int r = 0; r < 2; r++) begin
            rmode = (r == 0) ? 0 : 2;
            cfg(8);
            for (int i = 1; i <= 5; i++) send(i);
            do_flush(1'b1, 99);
            wait_idle("flush_fill");
        end

        // flush from RUN
        rmode = 0;
        cfg(4);
        for (int i = 1; i <= 9; i++) send(i);
        do_flush(1'b0, 0);
        wait_idle("flush_run");

        // reset mid-RUN, then no stale data afterwards
        cfg(3);
        for (int i = 1; i <= 6; i++) send(i);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_od", out_data, 0);
        chk("mid_rst_rdy", in_ready, 0);
        chk("mid_rst_fill", fill_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        cfg(2);
        send(5);
        send(6);
        send(7);
        @(negedge clk);
        chk("post_rst_first", out_data, 5);
        tick();
        do_flush(1'b0, 0);
        wait_idle("post_rst");

        // clamp 0 -> 1, signed extremes
        cfg(0);
        send(-64);
        send(63);
        send(-1);
        send(0);
        do_flush(1'b0, 0);
        wait_idle("clamp0");

        // clamp 40 -> 33
        cfg(40);
        for (int i = 0; i < 33; i++) send(int'($urandom_range(0, 127)));
        @(negedge clk);
        chk("d33_no_out", out_valid, 0);
        tick();
        send(-64);
        @(negedge clk);
        chk("d33_out", out_valid, 1);
        tick();
        send(63);
        do_flush(1'b0, 0);
        wait_idle("clamp40");

        // randomized runs
        for (int k = 0; k < 8; k++) begin
            rmode = int'($urandom_range(0, 2));
            cfg(int'($urandom_range(0, 40)));
            n = int'($urandom_range(0, 45));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                if ($urandom_range(0, 30) == 0) begin
                    do_flush(1'b1, int'($urandom_range(0, 127)));
                    break;
                end
                send(int'($urandom_range(0, 127)));
            end
            do_flush(1'b0, 0);
            wait_idle("rand");
        end

        rmode = 0;
        repeat (3) tick();
        chk("end_expq_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
